// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment driver for a packed BCD word, with a per-slot anode guard and a
// frame-latched shadow copy. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_display_scan #(
  parameter int DIGITS         = 5,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic [6:0]            Seg,
  output logic [DIGITS-1:0]     Anode,
  output logic                  Frame_Start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = SEG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                frame_q, frame_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   anode_q, anode_d;

  logic [3:0]          nibble;
  logic                selBlank;
  logic [DIGITS-1:0]   lzBlank;
  logic [DIGITS-1:0]   anodeActive;
  logic [6:0]          segActive;
  logic                inGuard;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hF:    g = 7'h00;
      default: g = 7'h40;
    endcase
    return g;
  endfunction

  // The shadow word is only reloaded as the last slot of a frame wraps, so a frame never tears.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d    = '0;
        shadow_d = BCD;
        frame_d  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic higherEmpty;
  always_comb begin
    lzBlank     = '0;
    higherEmpty = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (d > 0 && higherEmpty && shadow_q[4*d +: 4] == 4'h0) begin
        lzBlank[d] = 1'b1;
      end
      higherEmpty = higherEmpty &
                    (shadow_q[4*d +: 4] == 4'h0 || shadow_q[4*d +: 4] == 4'hF);
    end
  end
`else
  assign lzBlank = '0;
`endif

  always_comb begin
    nibble      = 4'hF;
    selBlank    = 1'b0;
    anodeActive = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) begin
        nibble         = shadow_q[4*d +: 4];
        selBlank       = lzBlank[d];
        anodeActive[d] = 1'b1;
      end
    end
  end

  assign segActive = selBlank ? 7'h00 : glyph(nibble);

  if (GUARD > 0) begin : g_guard
    assign inGuard = (int'(cnt_q) < GUARD);
  end else begin : g_noguard
    assign inGuard = 1'b0;
  end

  // XOR with the "off" pattern folds the drive polarity into the registered outputs.
  always_comb begin
    seg_d   = SEG_OFF;
    anode_d = AN_OFF;
    if (!inGuard) begin
      seg_d   = segActive ^ SEG_OFF;
      anode_d = anodeActive ^ AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '1;
      frame_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      anode_q  <= AN_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      anode_q  <= anode_d;
    end
  end

  assign Seg         = seg_q;
  assign Anode       = anode_q;
  assign Frame_Start = frame_q;

  a_anode_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(anode_q ^ AN_OFF));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_MAX);

endmodule
